// File: rtl/grant_sink.sv
// Consumes a one-hot arbiter grant, muxes the granted requester's word, and
// queues {src, data} in a small FIFO that drains over a valid/ready stream.
module grant_sink #(
  parameter int REQ_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int IDX_W     = $clog2(REQ_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_WIDTH-1:0]            grant,
  input  logic [REQ_WIDTH*DATA_WIDTH-1:0] req_data,
  output logic                            ready_out,
  output logic [REQ_WIDTH-1:0]            ack,
  output logic                            err_multi,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [IDX_W-1:0]                out_src,
  input  logic                            out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [REQ_WIDTH-1:0][DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0]                sel_data;
  logic [IDX_W-1:0]                     sel_idx;
  logic                                 g_any, g_multi, push, pop, multi;
  logic                                 started;
  logic [AW:0]                          count;
  logic [AW-1:0]                        wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]                mem_data [DEPTH];
  logic [IDX_W-1:0]                     mem_src  [DEPTH];

  // Per-requester masking; with a one-hot grant the OR-reduction is an exact mux.
  for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_lane
    assign lane_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[g]}};
  end

  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      sel_data = sel_data | lane_data[i];
      if (grant[i]) sel_idx = IDX_W'(i);
    end
  end

  assign g_any   = |grant;
  assign g_multi = |(grant & (grant - 1'b1));
  assign push    = ready_out && g_any && !g_multi;
  assign multi   = ready_out && g_multi;
  assign pop     = out_valid && out_ready;

  // Derived purely from flops, so out_ready never reaches ready_out combinationally.
  assign ready_out = started && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = mem_data[rd_ptr];
  assign out_src   = mem_src[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started   <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ack       <= '0;
      err_multi <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_src[i]  <= '0;
      end
    end else begin
      started   <= 1'b1;
      ack       <= push ? grant : '0;
      err_multi <= multi;
      if (push) begin
        mem_data[wr_ptr] <= sel_data;
        mem_src[wr_ptr]  <= sel_idx;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_grant_sink.sv
// Randomized and directed bench for grant_sink against a queue-based reference model.
module tb_grant_sink;
  localparam int REQ = 4, DW = 32, DEPTH = 4, IW = 2;

  logic              clk = 1'b0, rst = 1'b0;
  logic [REQ-1:0]    grant = '0;
  logic [REQ*DW-1:0] req_data = '0;
  logic              out_ready = 1'b0;
  logic              ready_out, err_multi, out_valid;
  logic [REQ-1:0]    ack;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_src;

  grant_sink #(.REQ_WIDTH(REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .grant(grant), .req_data(req_data),
    .ready_out(ready_out), .ack(ack), .err_multi(err_multi),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [IW-1:0] src; logic [DW-1:0] data; } ent_t;
  ent_t           q[$];
  bit             started;
  logic [REQ-1:0] exp_ack;
  bit             exp_err;
  int             errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    started = 0;
    exp_ack = '0;
    exp_err = 0;
  endtask

  task automatic check_outs();
    chk("ready_out", ready_out, started && q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() != 0);
    chk("ack", ack, exp_ack);
    chk("err_multi", err_multi, exp_err);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_src", out_src, q[0].src);
    end else if (!started) begin
      chk("rst_data", out_data, 0);
      chk("rst_src", out_src, 0);
    end
  endtask

  // One clock: check at negedge, advance the model at posedge, release inputs #1 later.
  task automatic cycle();
    int   n;
    bit   rdy, push, pop, multi;
    ent_t e;
    @(negedge clk);
    check_outs();
    n     = $countones(grant);
    rdy   = started && q.size() < DEPTH;
    push  = rdy && n == 1;
    multi = rdy && n > 1;
    pop   = q.size() != 0 && out_ready;
    e     = '0;
    for (int i = 0; i < REQ; i++)
      if (grant[i]) begin
        e.src  = IW'(i);
        e.data = req_data[i*DW +: DW];
      end
    @(posedge clk);
    if (rst) begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      exp_ack = push ? grant : '0;
      exp_err = multi;
      started = 1;
    end else model_reset();
    #1;
  endtask

  task automatic rand_data();
    req_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    model_reset();
    // Reset held with a grant present
    grant = 4'b0001;
    rand_data();
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    grant = '0;
    cycle();

    // Single transfer
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    grant = 4'b0100;
    cycle();
    grant = '0;
    repeat (3) cycle();
    chk("single_data", out_data, 32'hDEADBEEF);
    chk("single_src", out_src, 2);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();

    // Fill to full, then a grant that must be ignored
    for (int i = 0; i < 4; i++) begin
      grant = REQ'(1 << i);
      rand_data();
      cycle();
    end
    grant = 4'b0001;
    repeat (2) cycle();
    chk("full_ready", ready_out, 0);
    grant = '0;
    out_ready = 1'b1;
    repeat (4) cycle();
    out_ready = 1'b0;

    // Full plus a single pop with a held grant
    for (int i = 0; i < 4; i++) begin
      grant = REQ'(1 << i);
      rand_data();
      cycle();
    end
    grant = 4'b0010;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    grant = '0;
    out_ready = 1'b1;
    repeat (5) cycle();

    // Streaming at one word per cycle
    for (int i = 0; i < 16; i++) begin
      grant = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      rand_data();
      cycle();
      if (i > 0) chk("stream_ready", ready_out, 1);
    end
    grant = '0;
    repeat (2) cycle();
    out_ready = 1'b0;

    // Illegal multi-hot grant
    grant = 4'b0011;
    cycle();
    grant = '0;
    chk("err_pulse", err_multi, 1);
    repeat (2) cycle();

    // Three entries queued, then asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      grant = REQ'(1 << i);
      rand_data();
      cycle();
    end
    grant = '0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_valid", out_valid, 0);
    chk("async_ready", ready_out, 0);
    cycle();
    rst = 1'b1;
    repeat (2) cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       grant = '0;
        3:       grant = REQ'($urandom);
        default: grant = REQ'(1 << $urandom_range(0, REQ-1));
      endcase
      rand_data();
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    grant = '0;
    out_ready = 1'b1;
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
